// File: rtl/crypto_lib.sv
// Shared crypto library definitions: the health-test FSM encoding and the
// default cutoffs for the repetition-count and adaptive-proportion tests.
package crypto_lib;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_ALARM  = 2'd3
  } trng_state_e;

  localparam int unsigned RCT_CUTOFF_DEFAULT = 32;
  localparam int unsigned APT_WIN_DEFAULT    = 512;
  localparam int unsigned APT_CUTOFF_DEFAULT = 410;

endpackage

// File: rtl/trng_apt_window.sv
// Adaptive-proportion window: counts samples in a fixed-length window and
// the samples that match the window's first bit. Windows follow each other
// back to back. fail_o and winDone_o describe the sample presented this
// cycle, so the parent can act on the same edge that records the sample.
module trng_apt_window #(
  parameter int unsigned APT_WIN    = 512,
  parameter int unsigned APT_CUTOFF = 410,
  localparam int unsigned CW        = $clog2(APT_WIN + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_i,
  input  logic bit_i,
  input  logic clear_i,
  output logic fail_o,
  output logic winDone_o
);

  localparam logic [CW-1:0] WIN_LAST  = CW'(APT_WIN);
  localparam logic [CW-1:0] MATCH_CUT = CW'(APT_CUTOFF);

  logic [CW-1:0] winCnt_q, winCnt_d;
  logic [CW-1:0] matchCnt_q, matchCnt_d;
  logic          refBit_q, refBit_d;
  logic          openNew;
  logic          matchInc;

  // A count of zero (fresh start) or a full window means the next sample opens a new window.
  assign openNew = (winCnt_q == '0) || (winCnt_q == WIN_LAST);

  // Sample-driven next values; clear is applied in the register so fail_o never depends on it.
  always_comb begin
    winCnt_d   = winCnt_q;
    matchCnt_d = matchCnt_q;
    refBit_d   = refBit_q;
    matchInc   = 1'b0;
    if (sample_i) begin
      if (openNew) begin
        refBit_d   = bit_i;
        winCnt_d   = CW'(1);
        matchCnt_d = CW'(1);
      end else begin
        winCnt_d = winCnt_q + CW'(1);
        if (bit_i == refBit_q) begin
          matchCnt_d = matchCnt_q + CW'(1);
          matchInc   = 1'b1;
        end
      end
    end
    fail_o    = matchInc && (matchCnt_d == MATCH_CUT);
    winDone_o = sample_i && (winCnt_d == WIN_LAST);
  end

  // Window registers; clear discards all partial statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      winCnt_q   <= '0;
      matchCnt_q <= '0;
      refBit_q   <= 1'b0;
    end else if (clear_i) begin
      winCnt_q   <= '0;
      matchCnt_q <= '0;
      refBit_q   <= 1'b0;
    end else begin
      winCnt_q   <= winCnt_d;
      matchCnt_q <= matchCnt_d;
      refBit_q   <= refBit_d;
    end
  end

endmodule

// File: rtl/trng_health_test.sv
// Continuous health tests for a raw entropy source: repetition-count test,
// adaptive-proportion test (in trng_apt_window), warm-up/run/alarm FSM and
// the forwarding stage that feeds the Von Neumann corrector.
module trng_health_test
  import crypto_lib::*;
#(
  parameter int unsigned RCT_CUTOFF = RCT_CUTOFF_DEFAULT,
  parameter int unsigned APT_WIN    = APT_WIN_DEFAULT,
  parameter int unsigned APT_CUTOFF = APT_CUTOFF_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic raw_bit,
  input  logic raw_vld,
  input  logic clr_alarm,
  output logic dout,
  output logic dout_vld,
  output logic rct_fail,
  output logic apt_fail,
  output logic alarm,
  output logic ready
);

  localparam logic [7:0] RCT_CUT = 8'(RCT_CUTOFF);

  trng_state_e state_q, state_d;
  logic [7:0]  runCnt_q, runCnt_d;
  logic        lastBit_q, lastBit_d;
  logic        rctFail_q, rctFail_d;
  logic        aptFail_q, aptFail_d;
  logic        alarm_q;
  logic        dout_q, dout_d;
  logic        doutVld_q, doutVld_d;
  logic        sampleEn, rctHit, aptHit, anyHit;
  logic        clrEffect, clearCnt, winDone;

  // A sample is only evaluated while enabled and outside IDLE.
  assign sampleEn  = raw_vld && enable && (state_q != ST_IDLE);
  assign anyHit    = rctHit || aptHit;
  // A coinciding failure beats the clear request.
  assign clrEffect = clr_alarm && (state_q == ST_ALARM) && !anyHit;
  assign clearCnt  = !enable || (state_q == ST_IDLE) || clrEffect;

  trng_apt_window #(
    .APT_WIN    (APT_WIN),
    .APT_CUTOFF (APT_CUTOFF)
  ) u_apt (
    .clk       (clk),
    .rst_n     (rst_n),
    .sample_i  (sampleEn),
    .bit_i     (raw_bit),
    .clear_i   (clearCnt),
    .fail_o    (aptHit),
    .winDone_o (winDone)
  );

  // Repetition count: a zero run means no sample seen since the counters were cleared.
  always_comb begin
    lastBit_d = lastBit_q;
    runCnt_d  = runCnt_q;
    rctHit    = 1'b0;
    if (sampleEn) begin
      if ((runCnt_q == 8'd0) || (raw_bit != lastBit_q)) begin
        lastBit_d = raw_bit;
        runCnt_d  = 8'd1;
      end else if (runCnt_q != 8'hFF) begin
        runCnt_d = runCnt_q + 8'd1;
      end
      rctHit = (runCnt_d == RCT_CUT) && (runCnt_d != runCnt_q);
    end
  end

  // Next state, sticky flags and forwarding decision.
  always_comb begin
    state_d   = state_q;
    rctFail_d = rctFail_q || rctHit;
    aptFail_d = aptFail_q || aptHit;
    dout_d    = dout_q;
    doutVld_d = 1'b0;
    if (clrEffect) begin
      rctFail_d = 1'b0;
      aptFail_d = 1'b0;
    end
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = (rctFail_q || aptFail_q) ? ST_ALARM : ST_WARMUP;
        ST_WARMUP: begin
          if (anyHit)       state_d = ST_ALARM;
          else if (winDone) state_d = ST_RUN;
        end
        ST_RUN:    if (anyHit) state_d = ST_ALARM;
        ST_ALARM:  if (clrEffect) state_d = ST_WARMUP;
        default:   state_d = ST_IDLE;
      endcase
    end
    if ((state_q == ST_RUN) && sampleEn && !anyHit) begin
      dout_d    = raw_bit;
      doutVld_d = 1'b1;
    end
  end

  // State, statistics and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      runCnt_q  <= 8'd0;
      lastBit_q <= 1'b0;
      rctFail_q <= 1'b0;
      aptFail_q <= 1'b0;
      alarm_q   <= 1'b0;
      dout_q    <= 1'b0;
      doutVld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      runCnt_q  <= clearCnt ? 8'd0 : runCnt_d;
      lastBit_q <= clearCnt ? 1'b0 : lastBit_d;
      rctFail_q <= rctFail_d;
      aptFail_q <= aptFail_d;
      alarm_q   <= rctFail_d || aptFail_d;
      dout_q    <= dout_d;
      doutVld_q <= doutVld_d;
    end
  end

  assign dout     = dout_q;
  assign dout_vld = doutVld_q;
  assign rct_fail = rctFail_q;
  assign apt_fail = aptFail_q;
  assign alarm    = alarm_q;
  assign ready    = (state_q == ST_RUN);

endmodule

// File: doc/trng_health_test.md
TRNG_HEALTH_TEST -- requirements
Module: trng_health_test

Interface
REQ-001 The block SHALL have parameter RCT_CUTOFF, default 32, meaning the run length of identical raw bits that declares a repetition-count failure (range 2..255).
REQ-002 The block SHALL have parameter APT_WIN, default 512, meaning the adaptive-proportion window length in samples (range 16..4095).
REQ-003 The block SHALL have parameter APT_CUTOFF, default 410, meaning the match count within one window that declares an APT failure (range 2..APT_WIN).
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, named as in the rest of the codebase: clk (input, 1), the single clock, all state on its rising edge; rst_n (input, 1), asynchronous active-low reset.
REQ-005 The block SHALL have enable (input, 1): a level; high runs the tests, low returns the block to IDLE.
REQ-006 The block SHALL have raw_bit (input, 1): the raw entropy-source sample.
REQ-007 The block SHALL have raw_vld (input, 1): raw_bit is valid this cycle.
REQ-008 The block SHALL have clr_alarm (input, 1): a single-cycle pulse that clears sticky failures.
REQ-009 The block SHALL have dout (output, 1): the forwarded sample, which drives the Von Neumann corrector din.
REQ-010 The block SHALL have dout_vld (output, 1): dout is valid; a qualified sample.
REQ-011 The block SHALL have rct_fail (output, 1) and apt_fail (output, 1): sticky failure flags.
REQ-012 The block SHALL have alarm (output, 1): rct_fail OR apt_fail, registered.
REQ-013 The block SHALL have ready (output, 1): high in state RUN only.

Function
REQ-014 The FSM SHALL have states IDLE, WARMUP, RUN and ALARM; "sample" below means a cycle with raw_vld=1 in WARMUP, RUN or ALARM.
REQ-015 In IDLE with enable=1, the block SHALL move to WARMUP next cycle with all counters cleared; samples are not evaluated in IDLE.
REQ-016 WARMUP SHALL evaluate exactly APT_WIN samples, with no forwarding; with no failure, the block SHALL move to RUN on the cycle after the APT_WIN-th sample.
REQ-017 In RUN, for each sample, the block SHALL set dout=raw_bit and dout_vld=1 one cycle later (latency 1); otherwise dout_vld=0 and dout holds its value.
REQ-018 RCT: the block SHALL hold last_bit and an 8-bit run count; a sample equal to last_bit increments run (saturating at 255); a differing sample, or the first sample after IDLE, sets run=1 and last_bit=raw_bit.
REQ-019 RCT: when run reaches RCT_CUTOFF, rct_fail SHALL set on the following clock.
REQ-020 APT: the first sample of each window SHALL capture ref_bit and set win_cnt=1 and match=1; each later sample increments win_cnt, and increments match when raw_bit==ref_bit.
REQ-021 APT: when match reaches APT_CUTOFF, apt_fail SHALL set on the following clock.
REQ-022 APT: the sample that makes win_cnt==APT_WIN SHALL close the window; the next sample opens a new window with no gap sample.
REQ-023 Any failure in WARMUP or RUN SHALL move the block to ALARM on the same edge that sets the flag; the failing sample SHALL NOT be forwarded (dout_vld=0 for it).
REQ-024 In ALARM, dout_vld SHALL be 0, the tests SHALL keep running, and the flags SHALL remain set.
REQ-025 clr_alarm in ALARM SHALL clear rct_fail and apt_fail, clear the counters, and move the block to WARMUP (if enable=1) or IDLE (if enable=0).
REQ-026 clr_alarm outside ALARM SHALL have no effect.
REQ-027 If a new failure and clr_alarm occur in the same cycle, the failure SHALL win: the flags stay set and the state stays ALARM.
REQ-028 enable=0 in any state SHALL move the block to IDLE next cycle and clear the run, window and match counters; rct_fail and apt_fail SHALL persist until clr_alarm.
REQ-029 When enable=0 in ALARM, the block SHALL go to IDLE, and alarm SHALL stay high until clr_alarm.
REQ-030 Re-enabling with the flags still set SHALL enter ALARM directly, not WARMUP.
REQ-031 If raw_vld=0, no counter or state SHALL advance, except for the enable-driven transitions.
REQ-032 All comparisons SHALL be unsigned; counter widths are derived from the parameters with $clog2(APT_WIN+1).

Reset
REQ-033 On rst_n=0, the block SHALL enter IDLE and drive dout=0, dout_vld=0, rct_fail=0, apt_fail=0, alarm=0 and ready=0.
REQ-034 On rst_n=0, all counters, last_bit and ref_bit SHALL be 0.
REQ-035 Reset mid-window SHALL discard all partial statistics.
REQ-036 Reset removal SHALL be synchronised externally; the block needs no internal reset sequencing.

Structure
REQ-037 The FSM state encoding (2-bit) and the default cutoff constants SHALL live in the shared crypto_lib package.
REQ-038 The APT window/match counter pair SHALL be a sub-module, trng_apt_window, which takes the sample strobe, bit and clear inputs and produces the fail output.
REQ-039 RCT, the FSM and the output stage SHALL stay in the top-level module.

Verification
REQ-040 Reset, enable=1, and an alternating 0101... stream with raw_vld=1 every cycle -> ready rises exactly after 512 samples (+1 cycle), dout_vld then follows raw_vld with 1-cycle latency, and no flag is set.
REQ-041 In RUN, 32 consecutive 1s -> rct_fail=1 and alarm=1 on the clock after the 32nd; sample 32 is not forwarded; 31 ones followed by a 0 -> no failure.
REQ-042 An APT window with 410 matches to ref_bit -> apt_fail set on the 410th match; a window with 409 matches -> no failure, and the next window restarts at match=1.
REQ-043 In ALARM, pulse clr_alarm with enable=1 -> flags clear and the block goes to WARMUP; a clr_alarm coinciding with an RCT hit -> flags stay set.
REQ-044 Drop enable mid-window, then re-enable -> a fresh 512-sample warm-up; with a flag still uncleared, re-enable goes to ALARM.
REQ-045 Assert rst_n low mid-RUN -> all outputs read 0 asynchronously; with raw_vld gapped 1-in-3, latency and counts are unchanged per sample.
